// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared definitions for the pipeline control/hazard unit and the datapath.
package hazard_ctrl_unit_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Bit order is shared with the datapath: RegWrite is the MSB, ALUControl the LSBs.
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic [2:0] alu_control;
  } ctrl_bundle_t;

  localparam int CTRL_W = $bits(ctrl_bundle_t);

endpackage

// File: rtl/hazard_ctrl_unit_ctrl_pipe_reg.sv
// Control pipeline register: async active-low reset, synchronous clear
// used to inject a bubble.
module ctrl_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load every cycle; a clear loads an all-zero bubble instead.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   q <= '0;
    else if (clr) q <= '0;
    else          q <= d;
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Control-side companion to the 5-stage datapath: carries decoder controls
// through D/E, E/M, M/W and produces stall/flush/forward/PC-select signals.
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWriteD,
  input  logic             MemToRegD,
  input  logic             MemWriteD,
  input  logic             ALUSrcD,
  input  logic             RegDstD,
  input  logic             BranchD,
  input  logic             JumpD,
  input  logic [2:0]       ALUControlD,
  input  logic             branch_equal,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RtE,
  input  logic [REG_W-1:0] WriteRegE,
  input  logic [REG_W-1:0] WriteRegM,
  input  logic [REG_W-1:0] WriteRegW,
  output logic             RegDstE,
  output logic             ALUSrcE,
  output logic [2:0]       ALUControlE,
  output logic             MemWriteM,
  output logic             RegWriteW,
  output logic             MemToRegW,
  output logic             PCSrcD,
  output logic             JumpC,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] stall_count
);

  ctrl_bundle_t      ctrl_d, ctrl_e, ctrl_m, ctrl_w;
  logic [CTRL_W-1:0] de_q, em_q, mw_q;
  logic              lwstall, branchstall, stall;
  logic              ctrl_unused;

  // Register $0 is hardwired to zero, so it never creates a dependency.
  function automatic logic reg_hit(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  assign ctrl_d = {RegWriteD, MemToRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD};

  ctrl_pipe_reg #(.W(CTRL_W)) u_de (
    .clk(clk), .reset(reset), .clr(stall), .d(ctrl_d), .q(de_q)
  );
  ctrl_pipe_reg #(.W(CTRL_W)) u_em (
    .clk(clk), .reset(reset), .clr(1'b0), .d(ctrl_e), .q(em_q)
  );
  ctrl_pipe_reg #(.W(CTRL_W)) u_mw (
    .clk(clk), .reset(reset), .clr(1'b0), .d(ctrl_m), .q(mw_q)
  );

  assign ctrl_e = ctrl_bundle_t'(de_q);
  assign ctrl_m = ctrl_bundle_t'(em_q);
  assign ctrl_w = ctrl_bundle_t'(mw_q);

  // Writeback-stage fields that only the datapath ALU/dest path used earlier.
  assign ctrl_unused = ^{ctrl_w.mem_write, ctrl_w.alu_src, ctrl_w.reg_dst, ctrl_w.alu_control};

  assign RegDstE     = ctrl_e.reg_dst;
  assign ALUSrcE     = ctrl_e.alu_src;
  assign ALUControlE = ctrl_e.alu_control;
  assign MemWriteM   = ctrl_m.mem_write;
  assign RegWriteW   = ctrl_w.reg_write;
  assign MemToRegW   = ctrl_w.mem_to_reg;

  // Execute-stage forward select; the younger M-stage result wins over W.
  always_comb begin
    ForwardAE = FWD_RF;
    if (reg_hit(RsE, WriteRegM) && ctrl_m.reg_write)      ForwardAE = FWD_MEM;
    else if (reg_hit(RsE, WriteRegW) && ctrl_w.reg_write) ForwardAE = FWD_WB;
  end

  // Same rule for the B operand.
  always_comb begin
    ForwardBE = FWD_RF;
    if (reg_hit(RtE, WriteRegM) && ctrl_m.reg_write)      ForwardBE = FWD_MEM;
    else if (reg_hit(RtE, WriteRegW) && ctrl_w.reg_write) ForwardBE = FWD_WB;
  end

  assign ForwardAD = reg_hit(RsD, WriteRegM) && ctrl_m.reg_write;
  assign ForwardBD = reg_hit(RtD, WriteRegM) && ctrl_m.reg_write;

  assign lwstall = ctrl_e.mem_to_reg && (reg_hit(RtE, RsD) || reg_hit(RtE, RtD));

  // A branch compares in Decode, so it must wait for an ALU result still in E
  // or a load result still in M.
  assign branchstall = BranchD &&
      ((ctrl_e.reg_write  && (reg_hit(WriteRegE, RsD) || reg_hit(WriteRegE, RtD))) ||
       (ctrl_m.mem_to_reg && (reg_hit(WriteRegM, RsD) || reg_hit(WriteRegM, RtD))));

  assign stall  = lwstall || branchstall;
  assign StallF = stall;
  assign StallD = stall;
  assign FlushE = stall;

  assign PCSrcD = BranchD && branch_equal && !branchstall;
  // BranchD with JumpD is an illegal decode; the branch owns the PC then.
  assign JumpC  = JumpD && !stall && !BranchD;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         stall_count <= '0;
    else if (stall && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit. A second instance with a 4-bit
// counter exercises stall_count saturation in a short run.
module tb_hazard_ctrl_unit;

  localparam int REG_W = 5;
  localparam int CNT_W = 16;
  localparam int SAT_W = 4;

  localparam logic [7:0] C_NOP = 8'b0000_0000;
  localparam logic [7:0] C_ADD = 8'b1000_1010;
  localparam logic [7:0] C_LW  = 8'b1101_0010;
  localparam logic [7:0] C_SW  = 8'b0011_0010;

  typedef struct packed {
    logic [7:0]       ctl;
    logic             branch;
    logic             jump;
    logic             beq;
    logic [REG_W-1:0] rsd, rtd, rse, rte, wre, wrm, wrw;
  } stim_t;

  typedef struct packed {
    logic        reg_dst_e, alu_src_e;
    logic [2:0]  alu_ctl_e;
    logic        mem_write_m, reg_write_w, mem_to_reg_w;
    logic        pc_src, jump_c, stall, fad, fbd;
    logic [1:0]  fae, fbe;
    logic [15:0] cnt;
    logic [3:0]  sat;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic RegWriteD, MemToRegD, MemWriteD, ALUSrcD, RegDstD, BranchD, JumpD, branch_equal;
  logic [2:0] ALUControlD;
  logic [REG_W-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;

  logic RegDstE, ALUSrcE, MemWriteM, RegWriteW, MemToRegW, PCSrcD, JumpC;
  logic StallF, StallD, FlushE, ForwardAD, ForwardBD;
  logic [2:0] ALUControlE;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CNT_W-1:0] stall_count;

  logic s_RegDstE, s_ALUSrcE, s_MemWriteM, s_RegWriteW, s_MemToRegW, s_PCSrcD, s_JumpC;
  logic s_StallF, s_StallD, s_FlushE, s_ForwardAD, s_ForwardBD;
  logic [2:0] s_ALUControlE;
  logic [1:0] s_ForwardAE, s_ForwardBE;
  logic [SAT_W-1:0] s_stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_e = '0, m_m = '0, m_w = '0;
  int unsigned m_cnt = 0, m_sat = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .RegWriteD(RegWriteD), .MemToRegD(MemToRegD), .MemWriteD(MemWriteD),
    .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .BranchD(BranchD), .JumpD(JumpD),
    .ALUControlD(ALUControlD), .branch_equal(branch_equal),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegDstE(RegDstE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .MemWriteM(MemWriteM), .RegWriteW(RegWriteW), .MemToRegW(MemToRegW),
    .PCSrcD(PCSrcD), .JumpC(JumpC), .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .stall_count(stall_count)
  );

  hazard_ctrl_unit #(.REG_W(REG_W), .CNT_W(SAT_W)) u_sat (
    .clk(clk), .reset(reset),
    .RegWriteD(RegWriteD), .MemToRegD(MemToRegD), .MemWriteD(MemWriteD),
    .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .BranchD(BranchD), .JumpD(JumpD),
    .ALUControlD(ALUControlD), .branch_equal(branch_equal),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegDstE(s_RegDstE), .ALUSrcE(s_ALUSrcE), .ALUControlE(s_ALUControlE),
    .MemWriteM(s_MemWriteM), .RegWriteW(s_RegWriteW), .MemToRegW(s_MemToRegW),
    .PCSrcD(s_PCSrcD), .JumpC(s_JumpC), .StallF(s_StallF), .StallD(s_StallD), .FlushE(s_FlushE),
    .ForwardAD(s_ForwardAD), .ForwardBD(s_ForwardBD),
    .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE), .stall_count(s_stall_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic hit(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  task automatic apply(input stim_t s);
    {RegWriteD, MemToRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD} = s.ctl;
    BranchD = s.branch; JumpD = s.jump; branch_equal = s.beq;
    RsD = s.rsd; RtD = s.rtd; RsE = s.rse; RtE = s.rte;
    WriteRegE = s.wre; WriteRegM = s.wrm; WriteRegW = s.wrw;
  endtask

  // One clock cycle: drive at negedge, push expectation, sample, advance model.
  task automatic step(input stim_t s, input logic rst_v);
    exp_t e;
    exp_t g;
    logic lw, bs;
    @(negedge clk);
    reset = rst_v;
    apply(s);
    if (!rst_v) begin
      m_e = '0; m_m = '0; m_w = '0; m_cnt = 0; m_sat = 0;
    end
    lw = m_e[6] && (hit(s.rte, s.rsd) || hit(s.rte, s.rtd));
    bs = s.branch && ((m_e[7] && (hit(s.wre, s.rsd) || hit(s.wre, s.rtd))) ||
                      (m_m[6] && (hit(s.wrm, s.rsd) || hit(s.wrm, s.rtd))));
    e.stall        = lw || bs;
    e.reg_dst_e    = m_e[3];
    e.alu_src_e    = m_e[4];
    e.alu_ctl_e    = m_e[2:0];
    e.mem_write_m  = m_m[5];
    e.reg_write_w  = m_w[7];
    e.mem_to_reg_w = m_w[6];
    e.pc_src       = s.branch && s.beq && !bs;
    e.jump_c       = s.jump && !e.stall && !s.branch;
    e.fad          = hit(s.rsd, s.wrm) && m_m[7];
    e.fbd          = hit(s.rtd, s.wrm) && m_m[7];
    e.fae          = (hit(s.rse, s.wrm) && m_m[7]) ? 2'b10 : (hit(s.rse, s.wrw) && m_w[7]) ? 2'b01 : 2'b00;
    e.fbe          = (hit(s.rte, s.wrm) && m_m[7]) ? 2'b10 : (hit(s.rte, s.wrw) && m_w[7]) ? 2'b01 : 2'b00;
    e.cnt          = 16'(m_cnt);
    e.sat          = 4'(m_sat);
    exp_q.push_back(e);
    #2;
    g = exp_q.pop_front();
    check_eq("RegDstE", RegDstE, g.reg_dst_e);
    check_eq("ALUSrcE", ALUSrcE, g.alu_src_e);
    check_eq("ALUControlE", ALUControlE, g.alu_ctl_e);
    check_eq("MemWriteM", MemWriteM, g.mem_write_m);
    check_eq("RegWriteW", RegWriteW, g.reg_write_w);
    check_eq("MemToRegW", MemToRegW, g.mem_to_reg_w);
    check_eq("PCSrcD", PCSrcD, g.pc_src);
    check_eq("JumpC", JumpC, g.jump_c);
    check_eq("StallF", StallF, g.stall);
    check_eq("StallD", StallD, g.stall);
    check_eq("FlushE", FlushE, g.stall);
    check_eq("ForwardAD", ForwardAD, g.fad);
    check_eq("ForwardBD", ForwardBD, g.fbd);
    check_eq("ForwardAE", ForwardAE, g.fae);
    check_eq("ForwardBE", ForwardBE, g.fbe);
    check_eq("stall_count", stall_count, g.cnt);
    check_eq("sat_count", s_stall_count, g.sat);
    @(posedge clk);
    if (rst_v) begin
      m_w = m_m;
      m_m = m_e;
      m_e = e.stall ? 8'h00 : s.ctl;
      if (e.stall && m_cnt != 32'hFFFF) m_cnt++;
      if (e.stall && m_sat != 32'hF)    m_sat++;
    end
  endtask

  initial begin
    stim_t s;
    s = '0;
    apply(s);

    // Reset, then an add flowing through E, M and W.
    step(s, 1'b0);
    step(s, 1'b0);
    s = '0; s.ctl = C_ADD; step(s, 1'b1);
    s = '0;                step(s, 1'b1);
    // Execute forwarding: M match, W match, $0 never matches.
    s = '0; s.rse = 3; s.rte = 3; s.wrm = 3; s.rsd = 3; step(s, 1'b1);
    s = '0; s.rse = 3; s.rte = 5; s.wrm = 4; s.wrw = 3; step(s, 1'b1);
    s = '0; s.ctl = C_ADD; step(s, 1'b1);
    s = '0;                step(s, 1'b1);
    s = '0; s.rse = 0; s.wrm = 0; s.rsd = 0; s.rte = 0; step(s, 1'b1);
    // Load-use with a jump in Decode, then the bubble.
    s = '0; s.ctl = C_LW; step(s, 1'b1);
    s = '0; s.ctl = C_ADD; s.rte = 8; s.rsd = 8; s.jump = 1'b1; step(s, 1'b1);
    s = '0; s.ctl = C_ADD; s.rsd = 8; step(s, 1'b1);
    // Branch hazard on an ALU producer, resolved by forwarding from M.
    s = '0; s.ctl = C_ADD; step(s, 1'b1);
    s = '0; s.branch = 1'b1; s.beq = 1'b1; s.rsd = 5; s.wre = 5; step(s, 1'b1);
    s = '0; s.branch = 1'b1; s.beq = 1'b1; s.rsd = 5; s.wre = 5; s.wrm = 5; step(s, 1'b1);
    // Jump alone, then illegal branch+jump.
    s = '0; s.jump = 1'b1; step(s, 1'b1);
    s = '0; s.jump = 1'b1; s.branch = 1'b1; s.beq = 1'b1; step(s, 1'b1);
    // Branch waiting on a load in M, then a store through M.
    s = '0; s.ctl = C_LW; step(s, 1'b1);
    s = '0; s.rte = 9; s.rsd = 1; step(s, 1'b1);
    s = '0; s.branch = 1'b1; s.beq = 1'b1; s.rtd = 9; s.wrm = 9; step(s, 1'b1);
    s = '0; s.ctl = C_SW; step(s, 1'b1);
    s = '0; step(s, 1'b1);
    s = '0; step(s, 1'b1);

    // Random traffic over a small register range to provoke many matches.
    for (int i = 0; i < 200; i++) begin
      s.ctl    = 8'($urandom);
      s.branch = 1'($urandom_range(0, 1));
      s.jump   = 1'($urandom_range(0, 1));
      s.beq    = 1'($urandom_range(0, 1));
      s.rsd = 5'($urandom_range(0, 3)); s.rtd = 5'($urandom_range(0, 3));
      s.rse = 5'($urandom_range(0, 3)); s.rte = 5'($urandom_range(0, 3));
      s.wre = 5'($urandom_range(0, 3)); s.wrm = 5'($urandom_range(0, 3));
      s.wrw = 5'($urandom_range(0, 3));
      step(s, 1'b1);
    end

    // Sustained stall pressure: load-use then branch-on-load, repeatedly.
    for (int i = 0; i < 60; i++) begin
      s = '0; s.ctl = C_LW; s.rte = 7; s.rsd = 7; s.branch = 1'b1; s.wrm = 7;
      step(s, 1'b1);
    end
    check_eq("sat_hold", s_stall_count, 32'hF);

    // Asynchronous reset in mid-cycle: state clears with no clock edge.
    s = '0; s.ctl = C_LW; step(s, 1'b1);
    s = '0; s.ctl = C_ADD; step(s, 1'b1);
    #3;
    reset = 1'b0;
    #1;
    check_eq("async_stall_count", stall_count, 32'h0);
    check_eq("async_sat_count", s_stall_count, 32'h0);
    check_eq("async_RegDstE", RegDstE, 32'h0);
    check_eq("async_ALUSrcE", ALUSrcE, 32'h0);
    check_eq("async_ALUControlE", ALUControlE, 32'h0);
    check_eq("async_MemWriteM", MemWriteM, 32'h0);
    check_eq("async_RegWriteW", RegWriteW, 32'h0);
    check_eq("async_MemToRegW", MemToRegW, 32'h0);
    s = '0; step(s, 1'b0);
    s = '0; s.ctl = C_ADD; step(s, 1'b1);
    s = '0; step(s, 1'b1);
    s = '0; step(s, 1'b1);
    s = '0; step(s, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Control-side companion to the 5-stage pipelined datapath.
- Takes main-decoder control bits in Decode and carries them through the D/E, E/M and M/W control pipeline registers.
- Generates the datapath's stall, flush, forwarding and PC-select signals from the register addresses the datapath exports.
- Keeps a saturating stall-cycle counter for performance checks.

Parameters:
REG_W, 5, register-file address width (Rs/Rt/Rd/WriteReg fields)
CNT_W, 16, stall-cycle counter width

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
RegWriteD  in  1  decoder: instruction writes register file
MemToRegD  in  1  decoder: load (result from memory)
MemWriteD  in  1  decoder: store
ALUSrcD  in  1  decoder: ALU B operand is the sign-extended immediate
RegDstD  in  1  decoder: destination is Rd (1) or Rt (0)
BranchD  in  1  decoder: beq in Decode
JumpD  in  1  decoder: j in Decode
ALUControlD  in  3  decoder ALU op
branch_equal  in  1  datapath comparator result (Decode)
RsD, RtD  in  REG_W  Decode source registers (datapath A1/A2)
RsE, RtE  in  REG_W  Execute source registers
WriteRegE, WriteRegM, WriteRegW  in  REG_W  destination register per stage
RegDstE, ALUSrcE  out  1  Execute-stage controls
ALUControlE  out  3  Execute-stage ALU op
MemWriteM  out  1  Memory-stage store enable
RegWriteW, MemToRegW  out  1  Writeback-stage controls
PCSrcD  out  1  take branch (also clears the D registers)
JumpC  out  1  take jump
StallF, StallD, FlushE  out  1  hazard controls
ForwardAD, ForwardBD  out  1  Decode comparator forward from ALUOutM
ForwardAE, ForwardBE  out  2  00 = register file, 01 = ResultW, 10 = ALUOutM
stall_count  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (reset = 0, asynchronous):
  - All E/M/W control registers clear to 0, including RegWriteE, MemToRegE, MemWriteE, RegWriteM, MemToRegM.
  - stall_count clears to 0.
  - Consequently every registered output is 0 during reset.
  - Combinational outputs follow the D-stage inputs and the cleared registers.
  - Reset in mid-operation discards all in-flight controls; no partial write is ever issued.
- Pipeline:
  - D to E register loads {RegWrite, MemToReg, MemWrite, ALUSrc, RegDst, ALUControl} every cycle.
  - If FlushE = 1 that cycle, it loads all zeros (bubble) instead.
  - E to M and M to W registers always load; they are never stalled.
  - Latency: a D-stage control appears at E after 1 cycle, M after 2, W after 3.
- Register $0 (address 0) never matches in any forward or stall comparison below.
- Execute forwarding (combinational):
  - ForwardAE = 10 if RsE == WriteRegM and RegWriteM.
  - Otherwise ForwardAE = 01 if RsE == WriteRegW and RegWriteW.
  - Otherwise ForwardAE = 00. M stage has priority over W.
  - ForwardBE: identical rule using RtE.
- Decode forwarding:
  - ForwardAD = RsD == WriteRegM and RegWriteM.
  - ForwardBD = RtD == WriteRegM and RegWriteM.
- lwstall = MemToRegE and (RtE == RsD or RtE == RtD).
- branchstall = BranchD and either:
  - RegWriteE and WriteRegE in {RsD, RtD}, or
  - MemToRegM and WriteRegM in {RsD, RtD}.
- stall = lwstall or branchstall. StallF = StallD = FlushE = stall.
- PCSrcD = BranchD and branch_equal and not branchstall.
- JumpC = JumpD and not stall.
- Simultaneous BranchD and JumpD is illegal decoder output. If it occurs, PCSrcD takes priority and JumpC is forced to 0.
- stall_count increments by 1 on each clock edge where stall = 1. It holds at all-ones (saturates) and never wraps.

Decomposition:
- Shared package holds:
  - Forward-select constants FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - A packed control-bundle typedef {RegWrite, MemToReg, MemWrite, ALUSrc, RegDst, ALUControl[2:0]} so the datapath and this block agree on bit order.
- One sub-module is natural: ctrl_pipe_reg. It is a parameterised-width control register with async active-low reset and a synchronous clear, instantiated three times for D/E, E/M and M/W.
- The hazard and forward equations stay in the top level.

Test Plan:
- Reset and flow:
  - Stimulus: hold reset = 0 for 2 cycles, then release and drive add (RegWriteD = 1, RegDstD = 1, ALUControlD = 010).
  - Response: all outputs 0 during reset; RegDstE = 1 and ALUControlE = 010 after 1 cycle; RegWriteW = 1 after 3 cycles.
- Execute forwarding:
  - Stimulus 1: RsE = 3, WriteRegM = 3, RegWriteM = 1. Response: ForwardAE = 10.
  - Stimulus 2: add WriteRegW = 3 with RegWriteW = 1 and no M match. Response: ForwardAE = 01.
  - Stimulus 3: RsE = 0 with matching WriteRegM = 0. Response: ForwardAE = 00.
- Load-use:
  - Stimulus: lw to $8 in E (MemToRegE = 1, RtE = 8), RsD = 8.
  - Response: StallF = StallD = FlushE = 1 for exactly 1 cycle; next cycle E-stage controls are all 0 (bubble).
  - stall_count increments 0 to 1.
- Branch hazard:
  - Stimulus: BranchD = 1, branch_equal = 1, RsD = 5, RegWriteE = 1, WriteRegE = 5.
  - Response: PCSrcD = 0 and stall = 1.
  - Next cycle, with the producer in M and not a load: ForwardAD = 1, PCSrcD = 1.
- Jump and branch priority:
  - Stimulus 1: JumpD = 1 with no stall. Response: JumpC = 1.
  - Stimulus 2: JumpD = 1 during lwstall. Response: JumpC = 0.
  - Stimulus 3: BranchD = JumpD = 1 with branch_equal = 1. Response: PCSrcD = 1, JumpC = 0.
- Saturation and async reset:
  - Stimulus: force stall for 65540 cycles.
  - Response: stall_count = 0xFFFF and holds.
  - Then assert reset mid-cycle. Response: stall_count and all registered outputs go to 0 immediately, without waiting for a clock edge.
